// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
// The top-level shift_sub_div_4 also honours the optional DIV_ROUND_NEAREST_EN
// macro (round-to-nearest quotient); this package is the same in both builds.
package div_pkg;

  // Dividend/quotient width and divisor/remainder width.
  localparam int DW = 16;
  localparam int VW = 8;

  // Step counter is wide enough to count DW steps.
  localparam int CW = $clog2(DW) + 1;

  // Counter value during the final RUN step.
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  // Quotient reported for a division by zero.
  localparam logic [DW-1:0] DZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step_4.sv
// One compare-subtract step of a restoring divider. Purely combinational, so
// it can be replicated later to build an unrolled divider pipeline.
module div_step_4
  import div_pkg::*;
(
  input  logic [VW-1:0] rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          q_bit
);

  // The shifted remainder needs one extra bit. The partial remainder is always
  // below the divisor, so the difference fits back into VW bits.
  logic [VW:0] r_shift;

  // Shift in the next dividend bit, subtract when the divisor fits.
  always_comb begin
    r_shift  = {rem, bit_in};
    q_bit    = (r_shift >= {1'b0, divisor});
    rem_next = q_bit ? (r_shift[VW-1:0] - divisor) : r_shift[VW-1:0];
  end

endmodule

// File: rtl/shift_sub_div_4.sv
// Iterative restoring divider: 16-bit unsigned dividend by 8-bit unsigned
// divisor, one quotient bit per clock, start/rdy handshake.
// Optional macro DIV_ROUND_NEAREST_EN rounds the quotient to nearest
// (saturating); the remainder output always stays the truncated remainder.
module shift_sub_div_4
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          rdy,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_t        state;
  state_t        state_next;

  // The dividend register shifts left each step; quotient bits enter at the
  // bottom, so after DW steps it holds the quotient.
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW-1:0] rem;
  logic [CW-1:0] cnt;

  logic [VW-1:0] rem_next;
  logic          q_bit;
  logic          accept;
  logic          last_step;
  logic          dz_load;
  logic [DW-1:0] q_final;
  logic [DW-1:0] q_result;

  // A start coinciding with rdy is ignored, including the divide-by-zero case
  // where the rdy cycle is already spent in IDLE.
  assign accept    = (state == IDLE) && start && !rdy;
  assign last_step = (state == RUN) && (cnt == LAST_STEP);
  // Divide-by-zero passes through DONE with a zero divisor latched; the result
  // is loaded on leaving DONE so rdy lands one edge after acceptance.
  assign dz_load   = (state == DONE) && (dvs == '0);
  assign busy      = (state != IDLE);
  assign q_final   = {dvd[DW-2:0], q_bit};

  div_step_4 u_step (
    .rem      (rem),
    .bit_in   (dvd[DW-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

`ifdef DIV_ROUND_NEAREST_EN
  logic round_up;

  // Round up when the truncated remainder is at least half the divisor.
  always_comb begin
    round_up = ({rem_next, 1'b0} >= {1'b0, dvs});
    q_result = (round_up && (q_final != DZ_QUOTIENT)) ? q_final + 1'b1 : q_final;
  end
`else
  assign q_result = q_final;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and one restoring step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (accept) begin
      dvd <= dividend;
      dvs <= divisor;
      rem <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      dvd <= {dvd[DW-2:0], q_bit};
      rem <= rem_next;
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers and the one-cycle rdy pulse; results hold until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      rdy <= last_step || dz_load;
      if (last_step) begin
        quotient    <= q_result;
        remainder   <= rem_next;
        div_by_zero <= 1'b0;
      end else if (dz_load) begin
        quotient    <= DZ_QUOTIENT;
        remainder   <= dvd[VW-1:0];
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_sub_div_4.sv
// Self-checking bench for shift_sub_div_4: directed cases, busy/start-ignore
// behaviour, mid-operation reset and a randomized regression against an
// arithmetic reference model.
module tb_shift_sub_div_4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        rdy;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int rdy_count = 0;

  shift_sub_div_4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .rdy         (rdy),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which rdy is high.
  always @(negedge clk) if (rdy) rdy_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic dz, output int lat);
    int qi;
    int ri;
    if (b == 8'd0) begin
      q   = 16'hFFFF;
      r   = a[7:0];
      dz  = 1'b1;
      lat = 1;
    end else begin
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`ifdef DIV_ROUND_NEAREST_EN
      if ((2 * ri >= int'(b)) && (qi < 65535)) qi = qi + 1;
`endif
      q   = qi[15:0];
      r   = ri[7:0];
      dz  = 1'b0;
      lat = 16;
    end
  endfunction

  // Issue one division from IDLE and check latency, result and pulse width.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    int          elat;
    int          lat;
    model(a, b, eq, er, edz, elat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    starts++;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (rdy) begin
        lat = k - 1;
        break;
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(elat));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    if (b != 8'd0) begin
      check("rem_lt_divisor", 32'(remainder < b), 32'd1);
`ifndef DIV_ROUND_NEAREST_EN
      check("invariant", 32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
`endif
    end
    @(posedge clk);
    #1;
    check("rdy_one_cycle", 32'(rdy), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("quotient_hold", 32'(quotient), 32'(eq));
  endtask

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    int          elat;
    int          seen;
    int          rdy_before;
    logic [15:0] ra;
    logic [7:0]  rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    do_op(16'd1000, 8'd7);
    do_op(16'd65535, 8'd1);
    do_op(16'd3, 8'd200);
    do_op(16'd255, 8'd255);
    do_op(16'd5, 8'd0);
    do_op(16'd10, 8'd3);

    // Start pulses while busy and during rdy must be ignored.
    model(16'd1000, 8'd7, eq, er, edz, elat);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    starts++;
    seen = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3 || k == 16 || k == 17) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rdy) seen++;
      if (k == 16) begin
        check("spam_rdy_at_16", 32'(rdy), 32'd1);
        check("spam_busy_done", 32'(busy), 32'd1);
      end
      if (k == 17) check("spam_busy_low", 32'(busy), 32'd0);
    end
    check("spam_single_rdy", 32'(seen), 32'd1);
    check("spam_quotient", 32'(quotient), 32'(eq));
    check("spam_remainder", 32'(remainder), 32'(er));
    check("spam_idle", 32'(busy), 32'd0);

    // Divide by zero, a normal result clearing it, then another divide by
    // zero so the reset below has non-zero outputs to clear.
    do_op(16'd5, 8'd0);
    do_op(16'd10, 8'd3);
    do_op(16'd1234, 8'd0);

    // Asynchronous reset during RUN step 8.
    rdy_before = rdy_count;
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_rdy", 32'(rdy_count), 32'(rdy_before));
    do_op(16'd100, 8'd10);

    // Randomized regression, including zero divisors.
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(15) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(7) == 0) rb = 8'($urandom_range(3));
      do_op(ra, rb);
    end

    check("rdy_count_vs_starts", 32'(rdy_count), 32'(starts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
